// File: rtl/rename_pkg.sv
// Shared types, sizes and index helpers for the rename-stage physical tag free list.
package rename_pkg;

  localparam int NUM_PHYS    = 128;
  localparam int ARCH_REGS   = 32;
  localparam int TAG_W       = $clog2(NUM_PHYS);
  localparam int DEPTH       = NUM_PHYS - ARCH_REGS;
  localparam int IDX_W       = $clog2(DEPTH);
  localparam int CNT_W       = TAG_W + 1;
  localparam int INIT_CYCLES = DEPTH / 2;

  typedef logic [TAG_W-1:0] phys_tag_t;
  typedef logic [IDX_W-1:0] ring_idx_t;
  typedef logic [CNT_W-1:0] free_cnt_t;

  typedef enum logic {INIT, RUN} alloc_state_t;

  // DEPTH is not a power of two, so wrap with an explicit compare-and-subtract.
  function automatic ring_idx_t mod_add(input ring_idx_t idx, input logic [1:0] inc);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + {{(IDX_W-1){1'b0}}, inc};
    if (sum >= (IDX_W+1)'(DEPTH)) sum = sum - (IDX_W+1)'(DEPTH);
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/phys_tag_alloc_ctrl_tag_ring.sv
// Circular free-tag storage: two write ports for reclaim/init, two combinational read ports.
module tag_ring
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      we0,
  input  ring_idx_t widx0,
  input  phys_tag_t wdata0,
  input  logic      we1,
  input  ring_idx_t widx1,
  input  phys_tag_t wdata1,
  input  ring_idx_t ridx0,
  input  ring_idx_t ridx1,
  output phys_tag_t rdata0,
  output phys_tag_t rdata1
);

  phys_tag_t mem [DEPTH];

  // NOTE: storage has no reset; every entry is written during INIT before it can be read.
  always_ff @(posedge clk) begin
    if (we0) mem[widx0] <= wdata0;
    if (we1) mem[widx1] <= wdata1;
  end

  assign rdata0 = mem[ridx0];
  assign rdata1 = mem[ridx1];

endmodule

// File: rtl/phys_tag_alloc_ctrl.sv
// Free-list controller: fills the tag ring after reset, grants up to two tags and
// reclaims up to two tags per cycle, with sticky error on protocol violations.
module phys_tag_alloc_ctrl
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag0,
  output logic [TAG_W-1:0] alloc_tag1,
  output logic             stall_nophys,
  input  logic [1:0]       free_valid,
  input  logic [TAG_W-1:0] free_tag0,
  input  logic [TAG_W-1:0] free_tag1,
  output logic [TAG_W:0]   free_count,
  output logic             ready,
  output logic             error
);

  alloc_state_t state;
  ring_idx_t    head, tail, init_cnt;
  logic         run;
  logic [1:0]   req_n, grant_n, free_n;
  free_cnt_t    space;
  logic         acc0, acc1, drop;

  logic      we0, we1;
  ring_idx_t widx0, widx1;
  phys_tag_t wdata0, wdata1, rd0, rd1;

  assign run   = (state == RUN);
  assign req_n = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};

  // Grant is judged on the registered count only; same-cycle frees are not bypassed.
  assign alloc_gnt    = run && (free_cnt_t'(req_n) <= free_count);
  assign stall_nophys = (|alloc_req) && !alloc_gnt;
  assign grant_n      = alloc_gnt ? req_n : 2'd0;

  // Frees beyond the remaining space are dropped, port 1 first; anything outside RUN is dropped.
  assign space  = free_cnt_t'(DEPTH) - free_count;
  assign acc0   = run && free_valid[0] && (space != '0);
  assign acc1   = run && free_valid[1] && (acc0 ? (space >= free_cnt_t'(2)) : (space != '0));
  assign drop   = (free_valid[0] && !acc0) || (free_valid[1] && !acc1);
  assign free_n = {1'b0, acc0} + {1'b0, acc1};

  assign alloc_tag0 = rd0;
  assign alloc_tag1 = alloc_req[0] ? rd1 : rd0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    widx0  = tail;
    widx1  = mod_add(tail, 2'd1);
    wdata0 = free_tag0;
    wdata1 = free_tag1;
    if (!run) begin
      we0    = 1'b1;
      we1    = 1'b1;
      widx0  = ring_idx_t'(2 * int'(init_cnt));
      widx1  = ring_idx_t'(2 * int'(init_cnt) + 1);
      wdata0 = phys_tag_t'(ARCH_REGS + 2 * int'(init_cnt));
      wdata1 = phys_tag_t'(ARCH_REGS + 2 * int'(init_cnt) + 1);
    end else if (acc0) begin
      we0 = 1'b1;
      we1 = acc1;
    end else if (acc1) begin
      we0    = 1'b1;
      wdata0 = free_tag1;
    end
  end

  tag_ring u_ring (
    .clk    (clk),
    .we0    (we0),
    .widx0  (widx0),
    .wdata0 (wdata0),
    .we1    (we1),
    .widx1  (widx1),
    .wdata1 (wdata1),
    .ridx0  (head),
    .ridx1  (mod_add(head, 2'd1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      init_cnt   <= '0;
      free_count <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (drop) error <= 1'b1;
      if (state == INIT) begin
        init_cnt   <= init_cnt + ring_idx_t'(1);
        free_count <= free_count + free_cnt_t'(2);
        if (init_cnt == ring_idx_t'(INIT_CYCLES - 1)) begin
          state      <= RUN;
          ready      <= 1'b1;
          tail       <= '0;
          init_cnt   <= '0;
          free_count <= free_cnt_t'(DEPTH);
        end
      end else begin
        head       <= mod_add(head, grant_n);
        tail       <= mod_add(tail, free_n);
        free_count <= free_count + free_cnt_t'(free_n) - free_cnt_t'(grant_n);
      end
    end
  end

endmodule

// File: tb/tb_phys_tag_alloc_ctrl.sv
// Scoreboard bench for phys_tag_alloc_ctrl: a queue model of the free list predicts grants and tags.
module tb_phys_tag_alloc_ctrl;
  import rename_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] alloc_req;
  logic       alloc_gnt;
  phys_tag_t  alloc_tag0, alloc_tag1;
  logic       stall_nophys;
  logic [1:0] free_valid;
  phys_tag_t  free_tag0, free_tag1;
  free_cnt_t  free_count;
  logic       ready;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  int fl[$];
  int exp_q[$];
  bit model_err;

  always #5 clk = ~clk;

  phys_tag_alloc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag0   (alloc_tag0),
    .alloc_tag1   (alloc_tag1),
    .stall_nophys (stall_nophys),
    .free_valid   (free_valid),
    .free_tag0    (free_tag0),
    .free_tag1    (free_tag1),
    .free_count   (free_count),
    .ready        (ready),
    .error        (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, got, 32'hFFFF_FFFF);
    else check(tag, got, exp_q.pop_front());
  endtask

  // One RUN cycle: predict, drive, compare combinational outputs at negedge, then registered state.
  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input int t0, input int t1);
    int n, space;
    bit eg, a0, a1;
    alloc_req  = req;
    free_valid = fv;
    free_tag0  = phys_tag_t'(t0);
    free_tag1  = phys_tag_t'(t1);
    n  = int'(req[0]) + int'(req[1]);
    eg = (n <= fl.size());
    if (eg) begin
      if (req[0]) exp_q.push_back(fl[0]);
      if (req[1]) exp_q.push_back(req[0] ? fl[1] : fl[0]);
    end
    @(negedge clk);
    check("alloc_gnt", alloc_gnt, eg);
    check("stall_nophys", stall_nophys, (req != 2'b00) && !eg);
    if (alloc_gnt) begin
      if (req[0]) pop_check("alloc_tag0", alloc_tag0);
      if (req[1]) pop_check("alloc_tag1", alloc_tag1);
    end else begin
      exp_q.delete();
    end
    space = DEPTH - fl.size();
    if (eg) repeat (n) void'(fl.pop_front());
    a0 = fv[0] && (space >= 1);
    a1 = fv[1] && (space >= (a0 ? 2 : 1));
    if (a0) fl.push_back(t0);
    if (a1) fl.push_back(t1);
    if ((fv[0] && !a0) || (fv[1] && !a1)) model_err = 1'b1;
    @(posedge clk);
    #1;
    alloc_req  = 2'b00;
    free_valid = 2'b00;
    check("free_count", free_count, fl.size());
    check("error", error, model_err);
  endtask

  // One-cycle reset, then walk INIT with bounded wait for ready.
  task automatic reset_and_init(input logic [1:0] req_in_reset, input bit inject_free);
    int edges;
    bit seen;
    alloc_req  = req_in_reset;
    free_valid = 2'b00;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_free_count", free_count, 0);
    check("rst_error", error, 0);
    reset     = 1'b0;
    alloc_req = 2'b00;
    edges     = 0;
    seen      = 1'b0;
    while (!seen && edges < 200) begin
      if (edges == 3 && inject_free) begin
        free_valid = 2'b01;
        free_tag0  = phys_tag_t'(7);
      end
      if (edges == 5) begin
        alloc_req = 2'b11;
        @(negedge clk);
        check("init_gnt", alloc_gnt, 0);
        check("init_stall", stall_nophys, 1);
      end
      @(posedge clk);
      #1;
      edges++;
      alloc_req  = 2'b00;
      free_valid = 2'b00;
      if (edges == 10) check("init_free_count", free_count, 20);
      if (ready) seen = 1'b1;
    end
    check("ready_latency", edges, INIT_CYCLES);
    fl.delete();
    for (int i = ARCH_REGS; i < NUM_PHYS; i++) fl.push_back(i);
    exp_q.delete();
    model_err = inject_free;
    check("ready_free_count", free_count, DEPTH);
    check("ready_error", error, model_err);
  endtask

  initial begin
    reset      = 1'b1;
    alloc_req  = 2'b00;
    free_valid = 2'b00;
    free_tag0  = '0;
    free_tag1  = '0;
    model_err  = 1'b0;

    // Power-on fill
    reset_and_init(2'b00, 1'b0);

    // Drain the whole list in pairs, then one refused request
    for (int i = 0; i < DEPTH / 2; i++) drive(2'b11, 2'b00, 0, 0);
    drive(2'b11, 2'b00, 0, 0);

    // Single tag left: pair refused, lone slot-1 request served
    drive(2'b00, 2'b01, 40, 0);
    drive(2'b11, 2'b00, 0, 0);
    drive(2'b10, 2'b00, 0, 0);

    // Walk pointers to the wrap point, then allocate across it while freeing 5 and 6
    drive(2'b00, 2'b01, 50, 0);
    drive(2'b01, 2'b11, 51, 52);
    for (int i = 0; i < 46; i++) drive(2'b11, 2'b11, (2 * i) % 128, (2 * i + 1) % 128);
    drive(2'b11, 2'b11, 5, 6);
    drive(2'b11, 2'b00, 0, 0);

    // Fill to the brim, overflow on port 1 then on port 0
    for (int i = 0; i < 47; i++) drive(2'b00, 2'b11, (3 * i) % 128, (3 * i + 1) % 128);
    drive(2'b00, 2'b01, 8, 0);
    drive(2'b00, 2'b11, 9, 10);
    drive(2'b00, 2'b01, 7, 0);
    drive(2'b00, 2'b00, 0, 0);
    for (int i = 0; i < DEPTH / 2; i++) drive(2'b11, 2'b00, 0, 0);

    // Reset mid-run with requests outstanding
    drive(2'b00, 2'b11, 20, 21);
    drive(2'b01, 2'b00, 0, 0);
    reset_and_init(2'b11, 1'b0);
    drive(2'b11, 2'b00, 0, 0);
    drive(2'b01, 2'b00, 0, 0);

    // Free during INIT is a protocol error and must be discarded
    reset_and_init(2'b00, 1'b1);
    drive(2'b11, 2'b00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
